// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address helpers for the cache block-fill controller.
package cache_pkg;

    localparam int CACHE_ADDR_W      = 16;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    function automatic logic [CACHE_ADDR_W-1:0] block_base(input logic [CACHE_ADDR_W-1:0] addr);
        return addr & ~CACHE_ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word-index counter for one side of a block fill. It counts from a start index,
// wraps modulo the block size and raises done after one full lap.
module fill_counter
    import cache_pkg::*;
#(
    parameter int WIDTH = WORD_IDX_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] start_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_q;

    assign cnt_nxt = cnt_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            start_q <= '0;
            done_q  <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            start_q <= '0;
            done_q  <= 1'b0;
        end else if (load) begin
            cnt_q   <= start_val;
            start_q <= start_val;
            done_q  <= 1'b0;
        end else if (en && !done_q) begin
            cnt_q <= cnt_nxt;
            // Arriving back at the start index means every word has been visited.
            if (cnt_nxt == start_q) begin
                done_q <= 1'b1;
            end
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: stalls the pipeline and fills one block from main memory.
// Define CACHE_FILL_CRITICAL_FIRST_EN to fetch the missing word first (adds crit_word_ready).
//
//   state | meaning
//   IDLE  | no fill in progress; a miss starts one and stalls the same cycle
//   FILL  | requests issuing / words returning; leaves on the final word + tag write
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    output logic                               fsm_busy,
    output logic                               mem_req,
    output logic [ADDR_W-1:0]                  memory_address,
    input  logic                               memory_data_valid,
    input  logic [DATA_W-1:0]                  memory_data,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    output logic                               write_tag_array,
    output logic                               crit_word_ready
`else
    output logic                               write_tag_array
`endif
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [ADDR_W-1:0] base_q;
    logic              fill_start;
    logic              cnt_clear;
    logic              cnt_load;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  recv_start;
    logic [IDX_W-1:0]  issue_cnt;
    logic              issue_done;
    logic [IDX_W-1:0]  recv_cnt;
    logic [IDX_W-1:0]  recv_nxt;
    logic              recv_done;
    logic              recv_last;
    logic              rx_word;

    assign fill_start = (state_q == IDLE) && miss_detected;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    logic [IDX_W-1:0] crit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crit_q <= '0;
        end else if (fill_start) begin
            crit_q <= miss_address[IDX_W:1];
        end
    end

    assign cnt_clear  = 1'b0;
    assign cnt_load   = fill_start;
    assign start_idx  = miss_address[IDX_W:1];
    assign recv_start = crit_q;
`else
    assign cnt_clear  = fill_start;
    assign cnt_load   = 1'b0;
    assign start_idx  = '0;
    assign recv_start = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fill_start) begin
                base_q <= block_base(miss_address);
            end
        end
    end

    fill_counter #(.WIDTH(IDX_W)) u_issue_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .start_val (start_idx),
        .en        (mem_req),
        .cnt       (issue_cnt),
        .done      (issue_done)
    );

    fill_counter #(.WIDTH(IDX_W)) u_recv_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .start_val (start_idx),
        .en        (rx_word),
        .cnt       (recv_cnt),
        .done      (recv_done)
    );

    assign recv_nxt  = recv_cnt + IDX_W'(1);
    // The final word is the one whose successor index is back at the start index.
    assign recv_last = (recv_nxt == recv_start);

    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        memory_address   = '0;
        rx_word          = 1'b0;
        write_data_array = 1'b0;
        fill_word        = '0;
        write_tag_array  = 1'b0;
        fsm_busy         = 1'b0;

        case (state_q)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (!issue_done) begin
                    mem_req        = 1'b1;
                    memory_address = base_q | {{(ADDR_W-IDX_W-1){1'b0}}, issue_cnt, 1'b0};
                end
                if (memory_data_valid && !recv_done) begin
                    rx_word          = 1'b1;
                    write_data_array = 1'b1;
                    fill_word        = recv_cnt;
                    if (recv_last) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    // The first word of a fill is always the one at the start index.
    assign crit_word_ready = rx_word && (recv_cnt == crit_q);
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with an in-order fixed-latency memory model.
// Build with CACHE_FILL_CRITICAL_FIRST_EN to check the critical-word-first ordering.
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic        write_tag_array;
    logic        crit_word_ready;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        .write_tag_array   (write_tag_array),
        .crit_word_ready   (crit_word_ready)
`else
        .write_tag_array   (write_tag_array)
`endif
    );

`ifndef CACHE_FILL_CRITICAL_FIRST_EN
    assign crit_word_ready = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model state
    logic [15:0] q_a[$];
    int          q_t[$];
    int          cyc = 0;
    int          lat = 4;
    bit          gaps = 1'b0;

    // per-fill logs
    int          n_iss, n_wr, n_tag, n_val, n_crit, crit_at, tag_at_wr, busy_bad;
    logic [15:0] iss_addr[16];
    int          iss_cyc[16];
    logic [2:0]  wr_word[16];
    bit          in_fill, tag_seen;
    logic        s_busy, s_req, s_wr, s_tag;
    logic [15:0] s_addr;
    logic [2:0]  s_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_logs();
        n_iss = 0; n_wr = 0; n_tag = 0; n_val = 0; n_crit = 0;
        crit_at = -1; tag_at_wr = -1; busy_bad = 0;
        in_fill = 1'b0; tag_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            iss_addr[i] = '0; iss_cyc[i] = 0; wr_word[i] = '0;
        end
    endtask

    // Samples the current cycle, then advances to just after the next edge and
    // drives the memory return for the new cycle.
    task automatic cycle();
        #1;
        s_busy = fsm_busy; s_req = mem_req; s_addr = memory_address;
        s_wr = write_data_array; s_word = fill_word; s_tag = write_tag_array;
        if (in_fill && !fsm_busy) busy_bad++;
        if (mem_req) begin
            q_a.push_back(memory_address);
            q_t.push_back(cyc);
            if (n_iss < 16) begin
                iss_addr[n_iss] = memory_address;
                iss_cyc[n_iss]  = cyc;
            end
            n_iss++;
        end
        if (write_data_array) begin
            if (n_wr < 16) wr_word[n_wr] = fill_word;
            n_wr++;
        end
        if (crit_word_ready) begin
            n_crit++;
            crit_at = n_wr;
        end
        if (write_tag_array) begin
            n_tag++;
            tag_at_wr = n_wr;
            tag_seen  = 1'b1;
            in_fill   = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        if (q_a.size() > 0 && q_t[0] + lat <= cyc && !(gaps && $urandom_range(0, 1) == 0)) begin
            memory_data_valid = 1'b1;
            memory_data       = q_a[0] ^ 16'h5A5A;
            void'(q_a.pop_front());
            void'(q_t.pop_front());
            n_val++;
        end
    endtask

    task automatic run_fill(input logic [15:0] a, input int lat_i, input bit gaps_i,
                            input bit drop_i, input bit scramble_i);
        reset_logs();
        lat = lat_i; gaps = gaps_i;
        miss_address  = a;
        miss_detected = 1'b1;
        in_fill       = 1'b1;
        for (int i = 0; i < 100 && !tag_seen; i++) begin
            cycle();
            if (scramble_i) miss_address = ~a;
        end
        check("fill completes", {31'b0, tag_seen}, 32'd1);
        if (drop_i) miss_detected = 1'b0;
    endtask

    task automatic check_fill(input logic [15:0] a, input string name);
        logic [2:0]  start;
        logic [2:0]  w;
        logic [15:0] base;
        start = CRIT ? a[3:1] : 3'd0;
        base  = {a[15:4], 4'h0};
        check({name, " issue count"}, n_iss, 8);
        check({name, " issue span"}, iss_cyc[7] - iss_cyc[0], 7);
        for (int k = 0; k < 8; k++) begin
            w = 3'(start + 3'(k));
            check($sformatf("%s addr%0d", name, k), {16'h0, iss_addr[k]}, {16'h0, base | {12'h0, w, 1'b0}});
            check($sformatf("%s word%0d", name, k), {29'h0, wr_word[k]}, {29'h0, w});
        end
        check({name, " write count"}, n_wr, 8);
        check({name, " tag count"}, n_tag, 1);
        check({name, " tag on 8th write"}, tag_at_wr, 8);
        check({name, " busy throughout"}, busy_bad, 0);
        if (CRIT) begin
            check({name, " crit pulses"}, n_crit, 1);
            check({name, " crit on first write"}, crit_at, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        memory_data_valid = 1'b0; memory_data = '0;
        reset_logs();
        repeat (2) @(posedge clk);
        #1;

        // reset state
        cycle();
        check("rst busy", {31'b0, s_busy}, 0);
        check("rst mem_req", {31'b0, s_req}, 0);
        check("rst addr", {16'h0, s_addr}, 0);
        check("rst write", {31'b0, s_wr}, 0);
        check("rst fill_word", {29'b0, s_word}, 0);
        check("rst tag", {31'b0, s_tag}, 0);

        // spurious return in idle
        rst = 1'b0;
        memory_data_valid = 1'b1; memory_data = 16'hBEEF;
        cycle();
        check("idle spurious write", {31'b0, s_wr}, 0);
        check("idle busy", {31'b0, s_busy}, 0);

        // basic fill
        run_fill(16'h1234, 4, 1'b0, 1'b1, 1'b0);
        check_fill(16'h1234, "basic");
        cycle();
        check("basic busy after", {31'b0, s_busy}, 0);
        check("basic req after", {31'b0, s_req}, 0);

        // gapped returns with miss_address wandering mid-fill
        run_fill(16'h4562, 2, 1'b1, 1'b1, 1'b1);
        check_fill(16'h4562, "gapped");
        check("gapped writes==valids", n_wr, n_val);
        repeat (3) cycle();
        check("gapped no extra issue", n_iss, 8);
        gaps = 1'b0;

        // reset mid-fill
        reset_logs();
        lat = 4; miss_address = 16'h3000; miss_detected = 1'b1;
        for (int i = 0; i < 40 && n_wr < 3; i++) cycle();
        check("midrst reached 3 words", n_wr, 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0; miss_detected = 1'b0;
        q_a.delete(); q_t.delete();
        memory_data_valid = 1'b0;
        cycle();
        check("midrst busy", {31'b0, s_busy}, 0);
        check("midrst mem_req", {31'b0, s_req}, 0);
        check("midrst write", {31'b0, s_wr}, 0);
        check("midrst tag", {31'b0, s_tag}, 0);
        check("midrst addr", {16'h0, s_addr}, 0);
        check("midrst no tag at all", n_tag, 0);
        run_fill(16'h5008, 4, 1'b0, 1'b1, 1'b0);
        check_fill(16'h5008, "restart");
        cycle();

        // back-to-back misses with a spurious return in the idle cycle between them
        run_fill(16'h1000, 3, 1'b0, 1'b0, 1'b0);
        check_fill(16'h1000, "b2b first");
        miss_address = 16'h2000;
        memory_data_valid = 1'b1; memory_data = 16'hDEAD;
        cycle();
        check("b2b idle busy", {31'b0, s_busy}, 1);
        check("b2b idle mem_req", {31'b0, s_req}, 0);
        check("b2b idle write", {31'b0, s_wr}, 0);
        run_fill(16'h2000, 3, 1'b0, 1'b1, 1'b0);
        check_fill(16'h2000, "b2b second");
        cycle();

        // critical-word address (plain order unless the macro is defined)
        run_fill(16'hABCA, 4, 1'b0, 1'b1, 1'b0);
        check_fill(16'hABCA, "crit");
        cycle();

        // top-of-memory block
        run_fill(16'hFFFE, 4, 1'b0, 1'b1, 1'b0);
        check_fill(16'hFFFE, "wrap");
        cycle();
        check("wrap busy after", {31'b0, s_busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
